// File: rtl/nfc_frame_buffer.sv
// Frame store between the UART hex parser and the NFC transmit path: whole
// frames are buffered, released only once complete, and dropped whole when they cannot fit.
module nfc_frame_buffer #(
    parameter int AW = 10,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tvalid,
    input  logic [7:0]    i_tdata,
    input  logic [3:0]    i_tdatab,
    input  logic          i_tlast,
    output logic          o_tvalid,
    input  logic          o_tready,
    output logic [7:0]    o_tdata,
    output logic [3:0]    o_tdatab,
    output logic          o_tlast,
    output logic          o_drop,
    output logic [FW:0]   o_frames
);
    localparam int DEPTH = 1 << AW;
    localparam int NDESC = 1 << FW;
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_TWO  = {{(AW-1){1'b0}}, 2'b10};
    localparam logic [AW:0]   PTR_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_TWO  = {{(AW-2){1'b0}}, 2'b10};
    localparam logic [FW:0]   FR_ONE   = {{FW{1'b0}}, 1'b1};
    localparam logic [FW:0]   FR_FULL  = {1'b1, {FW{1'b0}}};
    localparam logic [3:0]    BITS_8   = 4'd8;

    // Output handshake: a byte moves on any rising edge where o_tvalid and
    // o_tready are both high; while o_tready is low the presented byte is held.
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t state_q, state_d;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    ram_q;
    logic [AW-1:0] raddr;
    logic [AW:0]   desc_len  [NDESC];
    logic [3:0]    desc_bits [NDESC];

    logic [AW:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, len_q, len_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d, remaining_q, remaining_d;
    logic [FW:0] dwr_q, dwr_d, drd_q, drd_d, frames_q, frames_d;
    logic        dropping_q, dropping_d, drop_q, drop_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [7:0]  tdata_q, tdata_d;
    logic [3:0]  tdatab_q, tdatab_d, cur_bits_q, cur_bits_d;
    logic        data_full, desc_full, drop_now, mem_we, desc_we, desc_pop, last_hs;
    logic [3:0]  bits_fix;

    // Fullness uses last cycle's read pointer, so freed space shows up one cycle late.
    assign data_full = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
    assign desc_full = frames_q == FR_FULL;
    assign bits_fix  = (i_tdatab == 4'd0 || i_tdatab > BITS_8) ? BITS_8 : i_tdatab;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        dropping_d  = dropping_q;
        drop_d      = 1'b0;
        drop_now    = dropping_q | data_full;
        mem_we      = 1'b0;
        desc_we     = 1'b0;
        dwr_d       = dwr_q;
        if (i_tvalid) begin
            mem_we = !drop_now;
            if (!drop_now) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (i_tlast) begin
                len_d = '0;
                if (!drop_now && !desc_full) begin
                    desc_we     = 1'b1;
                    dwr_d       = dwr_q + FR_ONE;
                    wr_commit_d = wr_ptr_q + PTR_ONE;
                end else begin
                    // Rewind over the partial frame; the transmitter never sees it.
                    wr_ptr_d   = wr_commit_q;
                    drop_d     = 1'b1;
                    dropping_d = 1'b0;
                end
            end else begin
                len_d      = len_q + PTR_ONE;
                dropping_d = drop_now;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tdatab_d    = tdatab_q;
        tlast_d     = tlast_q;
        cur_bits_d  = cur_bits_q;
        drd_d       = drd_q;
        desc_pop    = 1'b0;
        last_hs     = 1'b0;
        raddr       = rd_ptr_q[AW-1:0];
        unique case (state_q)
            IDLE: begin
                if (dwr_q != drd_q) begin
                    desc_pop    = 1'b1;
                    drd_d       = drd_q + FR_ONE;
                    remaining_d = desc_len[drd_q[FW-1:0]];
                    cur_bits_d  = desc_bits[drd_q[FW-1:0]];
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                raddr    = rd_ptr_q[AW-1:0] + ADR_ONE;
                tdata_d  = ram_q;
                tvalid_d = 1'b1;
                tlast_d  = remaining_q == PTR_ONE;
                tdatab_d = (remaining_q == PTR_ONE) ? cur_bits_q : BITS_8;
                state_d  = SEND;
            end
            SEND: begin
                // ram_q holds the byte after the one on the output: the prefetch slot.
                raddr = rd_ptr_q[AW-1:0] + ADR_ONE;
                if (tvalid_q && o_tready) begin
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    remaining_d = remaining_q - PTR_ONE;
                    if (remaining_q == PTR_ONE) begin
                        last_hs  = 1'b1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdatab_d = BITS_8;
                        state_d  = IDLE;
                    end else begin
                        raddr    = rd_ptr_q[AW-1:0] + ADR_TWO;
                        tdata_d  = ram_q;
                        tlast_d  = remaining_q == PTR_TWO;
                        tdatab_d = (remaining_q == PTR_TWO) ? cur_bits_q : BITS_8;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        unique case ({desc_we, last_hs})
            2'b10:   frames_d = frames_q + FR_ONE;
            2'b01:   frames_d = frames_q - FR_ONE;
            default: frames_d = frames_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= i_tdata;
        ram_q <= mem[raddr];
        if (desc_we) begin
            desc_len[dwr_q[FW-1:0]]  <= len_q + PTR_ONE;
            desc_bits[dwr_q[FW-1:0]] <= bits_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            dwr_q       <= '0;
            drd_q       <= '0;
            frames_q    <= '0;
            dropping_q  <= 1'b0;
            drop_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tdatab_q    <= BITS_8;
            tlast_q     <= 1'b0;
            cur_bits_q  <= BITS_8;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            dwr_q       <= dwr_d;
            drd_q       <= drd_d;
            frames_q    <= frames_d;
            dropping_q  <= dropping_d;
            drop_q      <= drop_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tdatab_q    <= tdatab_d;
            tlast_q     <= tlast_d;
            cur_bits_q  <= cur_bits_d;
        end
    end

    assign o_tvalid = tvalid_q;
    assign o_tdata  = tdata_q;
    assign o_tdatab = tdatab_q;
    assign o_tlast  = tlast_q;
    assign o_drop   = drop_q;
    assign o_frames = frames_q;
endmodule

// File: tb/tb_nfc_frame_buffer.sv
// Directed bench for nfc_frame_buffer: a default-size instance and a small
// one (16-byte buffer, 2 descriptors) share the input byte bus.
module tb_nfc_frame_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_vld, b_vld, in_last, a_rdy, b_rdy;
    logic [7:0] in_data;
    logic [3:0] in_bits;
    logic       a_ovld, b_ovld, a_olast, b_olast, a_drop, b_drop;
    logic [7:0] a_odata, b_odata;
    logic [3:0] a_obits, b_obits;
    logic [4:0] a_frames;
    logic [1:0] b_frames;

    int total = 0;
    int bad = 0;
    int a_drops = 0;
    int b_drops = 0;
    logic [12:0] exp_q[$];

    nfc_frame_buffer u_a (
        .clk(clk), .rst(rst),
        .i_tvalid(a_vld), .i_tdata(in_data), .i_tdatab(in_bits), .i_tlast(in_last),
        .o_tvalid(a_ovld), .o_tready(a_rdy), .o_tdata(a_odata), .o_tdatab(a_obits),
        .o_tlast(a_olast), .o_drop(a_drop), .o_frames(a_frames)
    );

    nfc_frame_buffer #(.AW(4), .FW(1)) u_b (
        .clk(clk), .rst(rst),
        .i_tvalid(b_vld), .i_tdata(in_data), .i_tdatab(in_bits), .i_tlast(in_last),
        .o_tvalid(b_ovld), .o_tready(b_rdy), .o_tdata(b_odata), .o_tdatab(b_obits),
        .o_tlast(b_olast), .o_drop(b_drop), .o_frames(b_frames)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (a_drop) a_drops++;
        if (b_drop) b_drops++;
    endtask

    task automatic push(input bit sel_b, input logic [7:0] d, input logic l, input logic [3:0] b);
        in_data = d;
        in_last = l;
        in_bits = b;
        if (sel_b) b_vld = 1'b1; else a_vld = 1'b1;
        tick();
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic chk_reset(input bit sel_b);
        chk("rst_tvalid", sel_b ? b_ovld : a_ovld, 0);
        chk("rst_tdata", sel_b ? b_odata : a_odata, 0);
        chk("rst_tdatab", sel_b ? b_obits : a_obits, 8);
        chk("rst_tlast", sel_b ? b_olast : a_olast, 0);
        chk("rst_drop", sel_b ? b_drop : a_drop, 0);
        chk("rst_frames", sel_b ? 32'(b_frames) : 32'(a_frames), 0);
    endtask

    task automatic collect(input bit sel_b, input int n, input bit toggle, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            logic r, v;
            logic [12:0] word;
            r = toggle ? c[0] : 1'b1;
            if (sel_b) b_rdy = r; else a_rdy = r;
            v = sel_b ? b_ovld : a_ovld;
            word = sel_b ? {b_olast, b_obits, b_odata} : {a_olast, a_obits, a_odata};
            if (v && r && exp_q.size() > 0) begin
                chk("out_byte", word, exp_q.pop_front());
                got++;
            end
            tick();
        end
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        chk("byte_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; in_data = '0; in_bits = '0;
        in_last = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
        tick();
        tick();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;

        // Single 5-byte frame streamed with o_tready held high.
        a_rdy = 1'b1;
        for (int k = 0; k < 5; k++) push(0, 8'(8'h11 * (k + 1)), k == 4, 4'd3);
        chk("t1_frames_up", a_frames, 1);
        chk("t1_tvalid_n1", a_ovld, 0);
        tick();
        chk("t1_tvalid_n2", a_ovld, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [12:0] w;
            w = {k == 4, (k == 4) ? 4'd3 : 4'd8, 8'(8'h11 * (k + 1))};
            chk("t1_tvalid", a_ovld, 1);
            chk("t1_byte", {a_olast, a_obits, a_odata}, w);
            tick();
        end
        chk("t1_tvalid_end", a_ovld, 0);
        chk("t1_frames_down", a_frames, 0);

        // Three 4-byte frames queued behind a stalled output, then a toggling ready.
        a_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(0, 8'(8'hA0 + i), (i % 4) == 3, 4'(5 + i / 4));
            exp_q.push_back({(i % 4) == 3, ((i % 4) == 3) ? 4'(5 + i / 4) : 4'd8, 8'(8'hA0 + i)});
        end
        chk("t2_frames", a_frames, 3);
        for (int j = 0; j < 3; j++) begin
            chk("t2_hold_valid", a_ovld, 1);
            chk("t2_hold_byte", {a_olast, a_obits, a_odata}, exp_q[0]);
            tick();
        end
        collect(0, 12, 1, 200);
        chk("t2_frames_end", a_frames, 0);

        // Small instance: second frame overflows the 16-byte buffer.
        for (int i = 0; i < 10; i++) push(1, 8'(8'h10 + i), i == 9, 4'd2);
        for (int i = 0; i < 8; i++) push(1, 8'(8'h40 + i), i == 7, 4'd8);
        tick();
        chk("t3_drop_low", b_drop, 0);
        chk("t3_drop_pulses", b_drops, 1);
        chk("t3_frames_1", b_frames, 1);
        for (int i = 0; i < 6; i++) push(1, 8'(8'h70 + i), i == 5, 4'd9);
        chk("t3_frames_2", b_frames, 2);
        chk("t3_drop_pulses2", b_drops, 1);
        for (int i = 0; i < 10; i++) exp_q.push_back({i == 9, (i == 9) ? 4'd2 : 4'd8, 8'(8'h10 + i)});
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 4'd8, 8'(8'h70 + i)});
        collect(1, 16, 0, 100);
        chk("t3_frames_end", b_frames, 0);

        // Small instance: only two committed frames fit in the descriptor queue.
        push(1, 8'hC1, 1'b1, 4'd4);
        push(1, 8'hC2, 1'b1, 4'd4);
        push(1, 8'hC3, 1'b1, 4'd4);
        tick();
        chk("t4_drop_pulses", b_drops, 2);
        chk("t4_frames", b_frames, 2);
        exp_q.push_back({1'b1, 4'd4, 8'hC1});
        exp_q.push_back({1'b1, 4'd4, 8'hC2});
        collect(1, 2, 0, 50);
        repeat (4) tick();
        chk("t4_idle_after", b_ovld, 0);
        chk("t4_frames_end", b_frames, 0);

        // Reset while a frame is mid-output and another is mid-input.
        for (int i = 0; i < 4; i++) push(0, 8'(8'hD0 + i), i == 3, 4'd8);
        for (int c = 0; c < 10 && !a_ovld; c++) tick();
        chk("t5_out_active", a_ovld, 1);
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        chk("t5_second_byte", a_odata, 8'hD1);
        push(0, 8'hE0, 1'b0, 4'd8);
        push(0, 8'hE1, 1'b0, 4'd8);
        rst = 1'b1;
        tick();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        push(0, 8'hF1, 1'b0, 4'd8);
        push(0, 8'hF2, 1'b0, 4'd8);
        push(0, 8'hF3, 1'b1, 4'd5);
        exp_q.push_back({1'b0, 4'd8, 8'hF1});
        exp_q.push_back({1'b0, 4'd8, 8'hF2});
        exp_q.push_back({1'b1, 4'd5, 8'hF3});
        collect(0, 3, 0, 50);
        repeat (4) tick();
        chk("t5_no_stale", a_ovld, 0);
        chk("t5_frames_end", a_frames, 0);

        // Commit lands on the same edge as the final handshake of the previous frame.
        a_rdy = 1'b1;
        push(0, 8'h31, 1'b1, 4'd7);
        tick();
        push(0, 8'h32, 1'b0, 4'd8);
        chk("t6_valid_before", a_ovld, 1);
        chk("t6_byte_before", {a_olast, a_obits, a_odata}, {1'b1, 4'd7, 8'h31});
        chk("t6_frames_before", a_frames, 1);
        push(0, 8'h33, 1'b1, 4'd6);
        chk("t6_frames_same", a_frames, 1);
        chk("t6_valid_after", a_ovld, 0);
        exp_q.push_back({1'b0, 4'd8, 8'h32});
        exp_q.push_back({1'b1, 4'd6, 8'h33});
        collect(0, 2, 0, 50);
        chk("t6_frames_end", a_frames, 0);
        chk("a_no_drops", a_drops, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
